// File: rtl/asrv32_stage_ctrl.sv
// asrv32_stage_ctrl: multi-cycle stage sequencer owning the PC, retire counter and trap redirection
module asrv32_stage_ctrl #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          MEM_TIMEOUT = 255,
    parameter int          TO_W        = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_halt,
    input  logic        i_imem_ack,
    input  logic        i_dmem_ack,
    input  logic        i_is_mem,
    input  logic        i_illegal,
    input  logic [31:0] i_next_pc,
    input  logic [31:0] i_trap_vector,
    output logic        o_fetch_en,
    output logic        o_decode_en,
    output logic        o_alu_en,
    output logic        o_mem_en,
    output logic        o_wb_en,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic [31:0] o_pc,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output logic [31:0] o_instret
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, TRAP} state_t;
    state_t          state, state_n;
    logic [TO_W-1:0] to_cnt;
    logic [1:0]      cause_n;
    logic            waiting, ack, timeout;
    assign waiting = (state == FETCH) || (state == MEMORY);
    assign ack     = (state == FETCH) ? i_imem_ack : i_dmem_ack;
    // an ack arriving on the final allowed cycle still wins over the timeout
    assign timeout = waiting && !ack && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
    always_comb begin
        state_n = state;
        cause_n = o_trap_cause;
        case (state)
            IDLE:      state_n = i_halt ? IDLE : FETCH;
            FETCH: begin
                if (i_imem_ack) state_n = DECODE;
                else if (timeout) begin
                    state_n = TRAP;
                    cause_n = 2'd1;
                end
            end
            DECODE: begin
                state_n = i_illegal ? TRAP : EXECUTE;
                cause_n = i_illegal ? 2'd0 : o_trap_cause;
            end
            EXECUTE:   state_n = i_is_mem ? MEMORY : WRITEBACK;
            MEMORY: begin
                if (i_dmem_ack) state_n = WRITEBACK;
                else if (timeout) begin
                    state_n = TRAP;
                    cause_n = 2'd2;
                end
            end
            WRITEBACK: state_n = i_halt ? IDLE : FETCH;
            TRAP:      state_n = i_halt ? IDLE : FETCH;
            default:   state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            to_cnt       <= '0;
            o_pc         <= RESET_PC;
            o_instret    <= '0;
            o_trap_cause <= 2'd0;
        end else begin
            state        <= state_n;
            to_cnt       <= (waiting && state_n == state) ? to_cnt + 1'b1 : '0;
            o_trap_cause <= cause_n;
            if (state == WRITEBACK) begin
                o_pc      <= i_next_pc;
                o_instret <= o_instret + 32'd1;
            end else if (state == TRAP) begin
                o_pc <= i_trap_vector;
            end
        end
    end
    assign o_fetch_en  = state == FETCH;
    assign o_decode_en = state == DECODE;
    assign o_alu_en    = state == EXECUTE;
    assign o_mem_en    = state == MEMORY;
    assign o_wb_en     = state == WRITEBACK;
    assign o_imem_req  = state == FETCH;
    assign o_dmem_req  = state == MEMORY;
    assign o_trap      = state == TRAP;
endmodule

// File: tb/tb_asrv32_stage_ctrl.sv
// tb_asrv32_stage_ctrl: directed self-checking bench for the stage sequencer
module tb_asrv32_stage_ctrl;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        halt = 1'b1, imem_ack = 1'b0, dmem_ack = 1'b0, is_mem = 1'b0, illegal = 1'b0;
    logic [31:0] next_pc = 32'h4, trap_vector = 32'h100;
    logic        fetch_en, decode_en, alu_en, mem_en, wb_en, imem_req, dmem_req, trap;
    logic [31:0] pc, instret;
    logic [1:0]  trap_cause;
    int          errors = 0, checks = 0;
    localparam logic [31:0] RPC = 32'h1000;
    localparam logic [4:0]  EN_F = 5'b10000, EN_D = 5'b01000, EN_E = 5'b00100,
                            EN_M = 5'b00010, EN_W = 5'b00001, EN_0 = 5'b00000;

    asrv32_stage_ctrl #(.RESET_PC(RPC), .MEM_TIMEOUT(4), .TO_W(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_imem_ack(imem_ack),
        .i_dmem_ack(dmem_ack), .i_is_mem(is_mem), .i_illegal(illegal),
        .i_next_pc(next_pc), .i_trap_vector(trap_vector),
        .o_fetch_en(fetch_en), .o_decode_en(decode_en), .o_alu_en(alu_en),
        .o_mem_en(mem_en), .o_wb_en(wb_en), .o_imem_req(imem_req), .o_dmem_req(dmem_req),
        .o_pc(pc), .o_trap(trap), .o_trap_cause(trap_cause), .o_instret(instret)
    );

    always #5 clk = ~clk;

    wire [4:0] en = {fetch_en, decode_en, alu_en, mem_en, wb_en};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_en", 32'(en), 32'(EN_0));
        chk("rst_pc", pc, RPC);
        chk("rst_instret", instret, 0);
        chk("rst_trap", {30'd0, trap_cause} | 32'(trap), 0);
        chk("rst_reqs", {30'd0, imem_req, dmem_req}, 0);
        rst_n = 1'b1;
        step();
        chk("halt_idle", 32'(en), 32'(EN_0));
        // plain ALU instruction, ack on first fetch cycle
        halt = 1'b0; imem_ack = 1'b1;
        step(); chk("add_f", 32'(en), 32'(EN_F)); chk("add_ireq", 32'(imem_req), 1);
        step(); chk("add_d", 32'(en), 32'(EN_D)); imem_ack = 1'b0;
        step(); chk("add_e", 32'(en), 32'(EN_E));
        step(); chk("add_w", 32'(en), 32'(EN_W)); chk("add_pc_hold", pc, RPC);
        step(); chk("add_next_f", 32'(en), 32'(EN_F)); chk("add_pc", pc, 32'h4);
        chk("add_instret", instret, 1);
        // load with three memory cycles
        imem_ack = 1'b1; is_mem = 1'b1; next_pc = 32'h8;
        step(); chk("ld_d", 32'(en), 32'(EN_D));
        step(); chk("ld_e", 32'(en), 32'(EN_E));
        step(); chk("ld_m1", 32'(en), 32'(EN_M)); chk("ld_dreq1", 32'(dmem_req), 1);
        step(); chk("ld_dreq2", 32'(dmem_req), 1);
        step(); chk("ld_dreq3", 32'(dmem_req), 1); dmem_ack = 1'b1;
        step(); chk("ld_w", 32'(en), 32'(EN_W)); chk("ld_dreq_off", 32'(dmem_req), 0);
        dmem_ack = 1'b0; is_mem = 1'b0;
        step(); chk("ld_pc", pc, 32'h8); chk("ld_instret", instret, 2);
        // illegal instruction trap
        step(); chk("ill_d", 32'(en), 32'(EN_D)); illegal = 1'b1;
        step(); chk("ill_trap", 32'(trap), 1); chk("ill_cause", 32'(trap_cause), 0);
        chk("ill_en", 32'(en), 32'(EN_0)); illegal = 1'b0;
        step(); chk("ill_pc", pc, 32'h100); chk("ill_instret", instret, 2);
        chk("ill_f", 32'(en), 32'(EN_F)); chk("ill_pulse", 32'(trap), 0);
        // instruction fetch timeout after four cycles
        imem_ack = 1'b0; trap_vector = 32'h200;
        step(); step();
        step(); chk("ito_f4", 32'(en), 32'(EN_F));
        step(); chk("ito_trap", 32'(trap), 1); chk("ito_cause", 32'(trap_cause), 1);
        step(); chk("ito_pc", pc, 32'h200);
        // ack on the last allowed cycle wins
        step(); step(); step(); chk("iack4_f4", 32'(en), 32'(EN_F)); imem_ack = 1'b1;
        step(); chk("iack4_d", 32'(en), 32'(EN_D)); chk("iack4_notrap", 32'(trap), 0);
        chk("iack4_cause_held", 32'(trap_cause), 1);
        // halt raised mid-instruction: retire, then idle
        step(); halt = 1'b1; next_pc = 32'h20;
        step(); chk("halt_w", 32'(en), 32'(EN_W));
        step(); chk("halt_idle2", 32'(en), 32'(EN_0)); chk("halt_pc", pc, 32'h20);
        chk("halt_instret", instret, 3);
        step(); chk("halt_stay", 32'(en), 32'(EN_0)); halt = 1'b0;
        step(); chk("unhalt_f", 32'(en), 32'(EN_F));
        // data memory timeout
        is_mem = 1'b1; trap_vector = 32'h300;
        step(); step(); imem_ack = 1'b0;
        step(); chk("dto_m1", 32'(en), 32'(EN_M));
        step(); step(); step(); chk("dto_m4", 32'(en), 32'(EN_M));
        step(); chk("dto_trap", 32'(trap), 1); chk("dto_cause", 32'(trap_cause), 2);
        chk("dto_instret", instret, 3);
        step(); chk("dto_pc", pc, 32'h300);
        // retire counter wrap
        imem_ack = 1'b1; is_mem = 1'b0; halt = 1'b1;
        step(); step(); step(); step();
        chk("wrap_idle", 32'(en), 32'(EN_0)); chk("wrap_pre", instret, 4);
        force dut.o_instret = 32'hFFFF_FFFF;
        #1 release dut.o_instret;
        chk("wrap_load", instret, 32'hFFFF_FFFF);
        halt = 1'b0; next_pc = 32'h40;
        step(); step(); step(); step(); step();
        chk("wrap_instret", instret, 0); chk("wrap_pc", pc, 32'h40);
        // async reset in the middle of a memory access
        is_mem = 1'b1;
        step(); step(); step(); chk("rstm_m", 32'(en), 32'(EN_M));
        #2 rst_n = 1'b0;
        #1;
        chk("rstm_en", 32'(en), 32'(EN_0)); chk("rstm_pc", pc, RPC);
        chk("rstm_instret", instret, 0); chk("rstm_dreq", 32'(dmem_req), 0);
        halt = 1'b1;
        step();
        rst_n = 1'b1;
        step(); chk("rstm_idle", 32'(en), 32'(EN_0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
